// File: rtl/fb_scanout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fb_scanout_pkg
//  Description : Shared constants, types and the pixel-to-address mapping
//                for the framebuffer scan-out reader.
//                - 640x480@60 Hz VGA timing. Pixel clock is 25 MHz.
//                - 320x240 framebuffer, 3-bit colour {R,G,B}.
//                - Every framebuffer pixel is shown 2x wide and 2x tall.
//  Revision    : 1.0 - initial release
// ============================================================================
package fb_scanout_pkg;

  // Framebuffer geometry
  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int ADDR_W  = 17;
  localparam int COLOR_W = 3;
  localparam int CNT_W   = 10;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [ADDR_W-1:0]  fb_addr_t;
  typedef logic [COLOR_W-1:0] color_t;

  // Horizontal timing, in pixels
  localparam int H_ACTIVE = 2 * FB_W;   // 640
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;  // 800

  // Vertical timing, in lines
  localparam int V_ACTIVE = 2 * FB_H;   // 480
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Counter-width versions of the timing boundaries. Sync ends are exclusive.
  localparam cnt_t H_VIS_END    = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_START = cnt_t'(H_ACTIVE + H_FRONT);
  localparam cnt_t H_SYNC_END   = cnt_t'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam cnt_t H_LAST       = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_VIS_END    = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SYNC_START = cnt_t'(V_ACTIVE + V_FRONT);
  localparam cnt_t V_SYNC_END   = cnt_t'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam cnt_t V_LAST       = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_LAST_VIS   = cnt_t'(V_ACTIVE - 1);

  // Timing bits carried alongside the RAM read, so that they line up with fb_q
  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
    logic en;
  } stage_t;

  // Idle value of a stage: syncs inactive, blanked, display disabled
  localparam stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1, en: 1'b0};

  // Framebuffer address of screen pixel (h,v) at 2x replication:
  // (v/2)*320 + h/2. The multiply by 320 is done as two shifts and an add.
  // The largest result is 76799, so 17 bits cannot overflow.
  function automatic fb_addr_t pixel_address(input cnt_t h, input cnt_t v);
    fb_addr_t x;
    fb_addr_t y;
    x = fb_addr_t'(h[CNT_W-1:1]);
    y = fb_addr_t'(v[CNT_W-1:1]);
    return (y << 8) + (y << 6) + x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_scanout_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_scanout_if
//  Description : Signal bundle between the scan-out reader and the outside.
//                It groups the framebuffer RAM read port with the VGA DAC
//                and sync pins.
//                - master : fb_scanout side. Drives the address and pins,
//                           and receives fb_q.
//                - slave  : RAM and display side.
//  Signals     : fb_address[16:0], fb_q[2:0], vga_hs, vga_vs, vga_blank_n,
//                vga_r/g/b[7:0], vblank, frame_start
//  Revision    : 1.0 - initial release
// ============================================================================
interface fb_scanout_if import fb_scanout_pkg::*; ();

  fb_addr_t   fb_address;
  color_t     fb_q;
  logic       vga_hs;
  logic       vga_vs;
  logic       vga_blank_n;
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;
  logic       vblank;
  logic       frame_start;

  modport master (
    output fb_address,
    input  fb_q,
    output vga_hs,
    output vga_vs,
    output vga_blank_n,
    output vga_r,
    output vga_g,
    output vga_b,
    output vblank,
    output frame_start
  );

  modport slave (
    input  fb_address,
    output fb_q,
    input  vga_hs,
    input  vga_vs,
    input  vga_blank_n,
    input  vga_r,
    input  vga_g,
    input  vga_b,
    input  vblank,
    input  frame_start
  );

endinterface
`default_nettype wire

// File: rtl/fb_scanout_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : S0 stage of the scan-out pipeline. It holds the 800x525
//                pixel/line counters and decodes them combinationally.
//                frame_start is registered. It is high in the cycle where the
//                counters read (h=0, v=480).
//  Ports       : clk          - pixel clock, rising edge
//                rst_n        - asynchronous reset, active low
//                hcount       - horizontal counter, 0..799
//                vcount       - vertical counter, 0..524
//                hs, vs       - sync, active low
//                blank        - 1 outside the 640x480 visible area
//                vblank       - 1 while vcount >= 480
//                frame_start  - one-cycle pulse at (h=0, v=480)
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen import fb_scanout_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  output cnt_t hcount,
  output cnt_t vcount,
  output logic hs,
  output logic vs,
  output logic blank,
  output logic vblank,
  output logic frame_start
);

  logic h_last;
  logic v_last;

  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
    end else begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
      // Decode one cycle early, so the pulse lines up with (0,480)
      // and still comes straight from a flop.
      frame_start <= h_last && (vcount == V_LAST_VIS);
    end
  end

  assign hs     = !((hcount >= H_SYNC_START) && (hcount < H_SYNC_END));
  assign vs     = !((vcount >= V_SYNC_START) && (vcount < V_SYNC_END));
  assign vblank = (vcount >= V_VIS_END);
  assign blank  = (hcount >= H_VIS_END) || vblank;

endmodule
`default_nettype wire

// File: rtl/fb_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : fb_scanout
//  Description : Framebuffer scan-out reader. It produces 640x480@60 Hz VGA
//                from a 320x240, 3-bit framebuffer, with 2x replication in
//                both axes. The pipeline has four stages:
//                  S0  counters and timing decode (vga_timing_gen)
//                  S1  registered framebuffer address, and timing/enable
//                      sample
//                  S2  RAM returns fb_q, and the timing is delayed one more
//                      stage
//                  S3  colour, sync and blank registered together onto the
//                      pins
//                Pins show the S0 state from three edges earlier.
//  Ports       : clock_all   - 25 MHz pixel clock
//                reset_all   - asynchronous reset, active low
//                enable_all  - 1 shows framebuffer content, 0 forces black
//                bus         - fb_scanout_if.master: fb_address, fb_q,
//                              vga_hs, vga_vs, vga_blank_n, vga_r/g/b,
//                              vblank, frame_start
//  Config      : FB_SCANOUT_TESTPAT_EN - when defined, colour is a bar
//                pattern taken from hcount[8:6] instead of fb_q.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_scanout import fb_scanout_pkg::*; (
  input  logic         clock_all,
  input  logic         reset_all,
  input  logic         enable_all,
  fb_scanout_if.master bus
);

  // --------------------------------------------------------------------------
  // S0: counters and timing decode
  // --------------------------------------------------------------------------
  cnt_t hcount;
  cnt_t vcount;
  logic hs0;
  logic vs0;
  logic blank0;
  logic vblank0;
  logic frame_start0;

  vga_timing_gen u_timing (
    .clk         (clock_all),
    .rst_n       (reset_all),
    .hcount      (hcount),
    .vcount      (vcount),
    .hs          (hs0),
    .vs          (vs0),
    .blank       (blank0),
    .vblank      (vblank0),
    .frame_start (frame_start0)
  );

  // --------------------------------------------------------------------------
  // S1/S2: address register and timing delay line.
  // The RAM register provides the S2 delay for the data path. The two
  // stage_t registers give the matching delay to the timing bits.
  // --------------------------------------------------------------------------
  stage_t s1;
  stage_t s2;

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      bus.fb_address <= '0;
      s1             <= STAGE_IDLE;
      s2             <= STAGE_IDLE;
    end else begin
      // Blanked pixels read address 0. This keeps the address bus quiet
      // outside the visible area.
      bus.fb_address <= blank0 ? '0 : pixel_address(hcount, vcount);
      s1             <= '{hs: hs0, vs: vs0, blank: blank0, en: enable_all};
      s2             <= s1;
    end
  end

  // --------------------------------------------------------------------------
  // Colour source
  // --------------------------------------------------------------------------
  color_t color_src;

`ifdef FB_SCANOUT_TESTPAT_EN
  // hcount is delayed by two stages so the bars line up with S3. The result
  // is 64-pixel bars in colours 0..7, then 0, 1 across the visible line.
  cnt_t h1;
  cnt_t h2;
  logic unused_testpat;

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      h1 <= '0;
      h2 <= '0;
    end else begin
      h1 <= hcount;
      h2 <= h1;
    end
  end

  assign color_src      = h2[8:6];
  assign unused_testpat = ^{bus.fb_q, h2[9], h2[5:0]};
`else
  assign color_src = bus.fb_q;
`endif

  // --------------------------------------------------------------------------
  // S3: output register. Sync, blank and colour change on the same edge.
  // --------------------------------------------------------------------------
  logic   hs_q;
  logic   vs_q;
  logic   blank_n_q;
  color_t color_q;

  always_ff @(posedge clock_all or negedge reset_all) begin
    if (!reset_all) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      color_q   <= '0;
    end else begin
      hs_q      <= s2.hs;
      vs_q      <= s2.vs;
      blank_n_q <= !s2.blank;
      color_q   <= (s2.blank || !s2.en) ? '0 : color_src;
    end
  end

  // Each colour bit drives all eight DAC bits of its channel
  assign bus.vga_hs      = hs_q;
  assign bus.vga_vs      = vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_r       = {8{color_q[2]}};
  assign bus.vga_g       = {8{color_q[1]}};
  assign bus.vga_b       = {8{color_q[0]}};

  // Frame-level status comes from S0. Drawers use it to schedule their
  // writes, so it is not delayed with the pixels.
  assign bus.vblank      = vblank0;
  assign bus.frame_start = frame_start0;

endmodule
`default_nettype wire
